// File: rtl/t5_pkg.sv
// Shared definitions for the t5 instruction-memory slice: data width and
// the wait-state controller's state encoding.
package t5_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NLANE = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } t5_state_e;

endpackage

// File: rtl/t5_ram_sp.sv
// Single-port synchronous RAM, read-first, with per-byte write enables.
// Read data register updates only on read accesses and clears on srst.
module t5_ram_sp
    import t5_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic             sclk,
    input  logic             srst,
    input  logic             ena,
    input  logic             rd_en,
    input  logic [NLANE-1:0] wr_sel,
    input  logic [AW-1:0]    addr,
    input  logic [XLEN-1:0]  wdt,
    output logic [XLEN-1:0]  rdt
);

    logic [XLEN-1:0] mem [2**AW];

    always_ff @(posedge sclk) begin
        if (ena) begin
            for (int unsigned n = 0; n < NLANE; n++) begin
                if (wr_sel[n]) begin
                    mem[addr][8*n +: 8] <= wdt[8*n +: 8];
                end
            end
        end
    end

    // Holding rdt across writes and idle cycles lets it serve directly as bus read data.
    always_ff @(posedge sclk) begin
        if (srst) begin
            rdt <= '0;
        end else if (ena && rd_en) begin
            rdt <= mem[addr];
        end
    end

endmodule

// File: rtl/t5_imem.sv
// Instruction memory with a registered Wishbone-style fetch port.
// Define T5_IMEM_WAIT_EN to add the IDLE/BUSY/ACK wait-state controller.
module t5_imem
    import t5_pkg::*;
#(
    parameter int unsigned AW   = 10,
    parameter int unsigned WAIT = 2
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic        sena,
    input  logic [31:2] iwb_adr,
    input  logic        iwb_stb,
    input  logic        iwb_wre,
    input  logic [3:0]  iwb_sel,
    input  logic [31:0] iwb_wdt,
    output logic [31:0] iwb_dat,
    output logic        iwb_ack
);

    logic             ram_go;
    logic             ram_ena;
    logic             ram_rd;
    logic [NLANE-1:0] ram_sel;
    logic [AW-1:0]    ram_addr;
    logic [XLEN-1:0]  ram_wdt;
    logic             ack_q;

    // Upper address bits are intentionally ignored so the memory aliases.
    logic unused_adr;
    assign unused_adr = ^iwb_adr[31:AW+2];

`ifdef T5_IMEM_WAIT_EN

    localparam logic [3:0] WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    t5_state_e        state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [AW-1:0]    lat_adr;
    logic             lat_wre;
    logic [NLANE-1:0] lat_sel;
    logic [XLEN-1:0]  lat_wdt;
    logic             accept;

    assign accept = sena && iwb_stb && (state == IDLE);

    // The RAM is touched only on the transition into ACK; with WAIT=0 that
    // happens in the accept cycle itself, so the live bus fields are used.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ram_go    = 1'b0;
        ram_rd    = 1'b0;
        ram_sel   = '0;
        ram_addr  = lat_adr;
        ram_wdt   = lat_wdt;
        if (sena) begin
            case (state)
                IDLE: begin
                    if (iwb_stb) begin
                        cnt_nxt = WAIT_LD;
                        if (WAIT == 0) begin
                            state_nxt = ACK;
                            ram_go    = 1'b1;
                            ram_rd    = ~iwb_wre;
                            ram_sel   = iwb_wre ? iwb_sel : '0;
                            ram_addr  = iwb_adr[AW+1:2];
                            ram_wdt   = iwb_wdt;
                        end else begin
                            state_nxt = BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state_nxt = ACK;
                        ram_go    = 1'b1;
                        ram_rd    = ~lat_wre;
                        ram_sel   = lat_wre ? lat_sel : '0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                ACK: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_q   <= 1'b0;
            lat_adr <= '0;
            lat_wre <= 1'b0;
            lat_sel <= '0;
            lat_wdt <= '0;
        end else if (sena) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ack_q <= (state_nxt == ACK);
            if (accept) begin
                lat_adr <= iwb_adr[AW+1:2];
                lat_wre <= iwb_wre;
                lat_sel <= iwb_sel;
                lat_wdt <= iwb_wdt;
            end
        end
    end

`else

    localparam int unsigned unused_wait = WAIT;

    assign ram_go   = sena && iwb_stb;
    assign ram_rd   = ~iwb_wre;
    assign ram_sel  = iwb_wre ? iwb_sel : '0;
    assign ram_addr = iwb_adr[AW+1:2];
    assign ram_wdt  = iwb_wdt;

    always_ff @(posedge sclk) begin
        if (srst) begin
            ack_q <= 1'b0;
        end else if (sena) begin
            ack_q <= iwb_stb;
        end
    end

`endif

    assign ram_ena = ram_go && !srst;

    t5_ram_sp #(
        .AW (AW)
    ) u_ram (
        .sclk   (sclk),
        .srst   (srst),
        .ena    (ram_ena),
        .rd_en  (ram_rd),
        .wr_sel (ram_sel),
        .addr   (ram_addr),
        .wdt    (ram_wdt),
        .rdt    (iwb_dat)
    );

    assign iwb_ack = ack_q;

endmodule

// File: tb/tb_t5_imem.sv
// Self-checking bench for t5_imem: directed vector table plus randomized
// traffic against a word-array reference model (zero-wait build), or
// hand-written wait-state sequences when T5_IMEM_WAIT_EN is defined.
module tb_t5_imem;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAIT  = 2;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena;
    logic [29:0] adr;
    logic        stb;
    logic        wre;
    logic [3:0]  sel;
    logic [31:0] wdt;
    logic [31:0] dat;
    logic        ack;

    always #5 sclk = ~sclk;

    t5_imem #(
        .AW   (AW),
        .WAIT (WAIT)
    ) dut (
        .sclk    (sclk),
        .srst    (srst),
        .sena    (sena),
        .iwb_adr (adr),
        .iwb_stb (stb),
        .iwb_wre (wre),
        .iwb_sel (sel),
        .iwb_wdt (wdt),
        .iwb_dat (dat),
        .iwb_ack (ack)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    logic        ref_ack = 1'b0;
    logic [31:0] ref_dat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of bus inputs, then sample just after the rising edge.
    task automatic drive(input logic r, input logic en, input logic s, input logic w,
                         input logic [3:0] sl, input logic [29:0] a, input logic [31:0] d);
        srst = r; sena = en; stb = s; wre = w; sel = sl; adr = a; wdt = d;
        @(posedge sclk);
        #1;
    endtask

    // Zero-wait reference: one access per enabled strobed cycle.
    task automatic model_step(input logic r, input logic en, input logic s, input logic w,
                              input logic [3:0] sl, input logic [29:0] a, input logic [31:0] d);
        int idx;
        if (r) begin
            ref_ack = 1'b0;
            ref_dat = '0;
        end else if (en) begin
            ref_ack = s;
            if (s) begin
                idx = int'(a) % DEPTH;
                if (!w) begin
                    ref_dat = ref_mem[idx];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (sl[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        stb;
        logic        wre;
        logic [3:0]  sel;
        logic [29:0] adr;
        logic [31:0] wdt;
        logic        ack;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[$];

`ifdef T5_IMEM_WAIT_EN
    // Bounded wait for an acknowledge while holding the bus idle.
    task automatic wait_ack(input string name, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
            if (ack === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: no ack within 40 cycles, expected one", name);
        end
    endtask
`endif

    initial begin
        srst = 1'b1; sena = 1'b0; stb = 1'b0; wre = 1'b0;
        sel = 4'h0; adr = '0; wdt = '0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_dat", dat, 32'h0);

`ifdef T5_IMEM_WAIT_EN
        begin
            bit seen;
            logic        exp_ack;
            logic [31:0] exp_dat;
            // Write accepted at edge 0; read held on stb from edge 1 must wait for IDLE.
            drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 30'd7, 32'h12345678);
            for (int k = 0; k <= int'(2*WAIT + 2); k++) begin
                if (k > 0) drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 30'd7, 32'd0);
                exp_ack = (k == int'(WAIT)) || (k == int'(2*WAIT + 2));
                exp_dat = (k >= int'(2*WAIT + 2)) ? 32'h12345678 : 32'h0;
                check($sformatf("wait_ack_e%0d", k), {31'd0, ack}, {31'd0, exp_ack});
                check($sformatf("wait_dat_e%0d", k), dat, exp_dat);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
            check("wait_ack_drop", {31'd0, ack}, 32'd0);

            // Write abandoned by a reset pulse in BUSY.
            drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 30'd7, 32'hFFFFFFFF);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
            for (int k = 0; k < int'(WAIT + 3); k++) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
                check($sformatf("rst_noack_%0d", k), {31'd0, ack}, 32'd0);
            end
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 30'd7, 32'd0);
            wait_ack("rst_readback_ack", seen);
            check("rst_readback_dat", dat, 32'h12345678);

            // Stall while acknowledged: ack and data hold, then drop.
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 30'd7, 32'd0);
            wait_ack("stall_ack", seen);
            for (int k = 0; k < 3; k++) begin
                drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 30'd7, 32'd0);
                check($sformatf("stall_hold_ack_%0d", k), {31'd0, ack}, 32'd1);
                check($sformatf("stall_hold_dat_%0d", k), dat, 32'h12345678);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 30'd0, 32'd0);
            check("stall_release", {31'd0, ack}, 32'd0);
        end
`else
        //                name          rst  en   stb  wre  sel    adr      wdt            ack  dat
        tbl.push_back('{"wr5",         1'b0,1'b1,1'b1,1'b1,4'hF, 30'd5,   32'hDEADBEEF, 1'b1, 32'h00000000});
        tbl.push_back('{"rd5",         1'b0,1'b1,1'b1,1'b0,4'h0, 30'd5,   32'h0,        1'b1, 32'hDEADBEEF});
        tbl.push_back('{"wr3_full",    1'b0,1'b1,1'b1,1'b1,4'hF, 30'd3,   32'h11223344, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{"wr3_lanes",   1'b0,1'b1,1'b1,1'b1,4'h5, 30'd3,   32'hAABBCCDD, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{"rd3_lanes",   1'b0,1'b1,1'b1,1'b0,4'h0, 30'd3,   32'h0,        1'b1, 32'h11BB33DD});
        tbl.push_back('{"wr0",         1'b0,1'b1,1'b1,1'b1,4'hF, 30'd0,   32'hA0A0A0A0, 1'b1, 32'h11BB33DD});
        tbl.push_back('{"wr1",         1'b0,1'b1,1'b1,1'b1,4'hF, 30'd1,   32'hA1A1A1A1, 1'b1, 32'h11BB33DD});
        tbl.push_back('{"wr2",         1'b0,1'b1,1'b1,1'b1,4'hF, 30'd2,   32'hA2A2A2A2, 1'b1, 32'h11BB33DD});
        tbl.push_back('{"stream0",     1'b0,1'b1,1'b1,1'b0,4'h0, 30'd0,   32'h0,        1'b1, 32'hA0A0A0A0});
        tbl.push_back('{"stream1",     1'b0,1'b1,1'b1,1'b0,4'h0, 30'd1,   32'h0,        1'b1, 32'hA1A1A1A1});
        tbl.push_back('{"stream2",     1'b0,1'b1,1'b1,1'b0,4'h0, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"stream3",     1'b0,1'b1,1'b1,1'b0,4'h0, 30'd3,   32'h0,        1'b1, 32'h11BB33DD});
        tbl.push_back('{"no_stb",      1'b0,1'b1,1'b0,1'b0,4'h0, 30'd0,   32'h0,        1'b0, 32'h11BB33DD});
        tbl.push_back('{"alias",       1'b0,1'b1,1'b1,1'b0,4'h0, 30'd453, 32'h0,        1'b1, 32'hDEADBEEF});
        tbl.push_back('{"pre_stall",   1'b0,1'b1,1'b1,1'b0,4'h0, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"stall1",      1'b0,1'b0,1'b1,1'b1,4'hF, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"stall2",      1'b0,1'b0,1'b1,1'b1,4'hF, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"stall3",      1'b0,1'b0,1'b1,1'b1,4'hF, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"stall_rel",   1'b0,1'b1,1'b0,1'b0,4'h0, 30'd0,   32'h0,        1'b0, 32'hA2A2A2A2});
        tbl.push_back('{"stall_nowr",  1'b0,1'b1,1'b1,1'b0,4'h0, 30'd2,   32'h0,        1'b1, 32'hA2A2A2A2});
        tbl.push_back('{"rst_rd",      1'b1,1'b1,1'b1,1'b0,4'h0, 30'd0,   32'h0,        1'b0, 32'h00000000});
        tbl.push_back('{"mem_kept",    1'b0,1'b1,1'b1,1'b0,4'h0, 30'd1,   32'h0,        1'b1, 32'hA1A1A1A1});
        tbl.push_back('{"rst_no_ena",  1'b1,1'b0,1'b0,1'b0,4'h0, 30'd0,   32'h0,        1'b0, 32'h00000000});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].stb, tbl[i].wre, tbl[i].sel, tbl[i].adr, tbl[i].wdt);
            model_step(tbl[i].rst, tbl[i].en, tbl[i].stb, tbl[i].wre, tbl[i].sel, tbl[i].adr, tbl[i].wdt);
            check({tbl[i].name, "_ack"}, {31'd0, ack}, {31'd0, tbl[i].ack});
            check({tbl[i].name, "_dat"}, dat, tbl[i].dat);
        end

        // Fill every word so every random read has a known answer.
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [31:0] d;
            d = $urandom;
            drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 30'(i), d);
            model_step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 30'(i), d);
            check("fill_ack", {31'd0, ack}, {31'd0, ref_ack});
        end

        for (int i = 0; i < 500; i++) begin
            logic        r, en, s, w;
            logic [3:0]  sl;
            logic [29:0] a;
            logic [31:0] d;
            r  = ($urandom_range(39) == 0);
            en = ($urandom_range(3) != 0);
            s  = ($urandom_range(4) != 0);
            w  = ($urandom_range(2) == 0);
            sl = 4'($urandom);
            a  = 30'($urandom);
            d  = $urandom;
            drive(r, en, s, w, sl, a, d);
            model_step(r, en, s, w, sl, a, d);
            check($sformatf("rand%0d_ack", i), {31'd0, ack}, {31'd0, ref_ack});
            check($sformatf("rand%0d_dat", i), dat, ref_dat);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/t5_imem.md
T5_IMEM -- requirements
Module: t5_imem

Interface
REQ-001 Parameter AW, default 10: word-address width; memory depth is 2^AW 32-bit words.
REQ-002 Parameter WAIT, default 2: wait states per access; range 0..15; used only when T5_IMEM_WAIT_EN is defined.
REQ-003 sclk  input  1  the single clock; all state updates on its rising edge.
REQ-004 srst  input  1  reset; synchronous and active-high.
REQ-005 sena  input  1  global stall-enable; when low, all state, including memory writes, holds.
REQ-006 iwb_adr  input  30 [31:2]  word address from the fetch initiator.
REQ-007 iwb_stb  input  1  request strobe.
REQ-008 iwb_wre  input  1  write enable (1 = write, 0 = read).
REQ-009 iwb_sel  input  4  byte-lane selects for writes; lane n maps to bits [8n+7:8n].
REQ-010 iwb_wdt  input  32  write data.
REQ-011 iwb_dat  output  32  registered read data.
REQ-012 iwb_ack  output  1  registered one-cycle acknowledge, one per accepted request.

Function
REQ-013 Decode: the word index is iwb_adr[AW+1:2]; higher address bits are ignored, so the memory aliases across the address space.
REQ-014 Acceptance: a request is accepted on a sena=1 edge with iwb_stb=1 while the FSM is in IDLE (or always, in zero-wait mode).
REQ-015 Zero-wait mode: an accepted request drives iwb_ack=1 on the next edge, with iwb_dat = the word at the request address.
REQ-016 Zero-wait throughput: a new request is accepted every sena cycle, giving a back-to-back pipelined stream with one ack per cycle; iwb_stb=0 yields iwb_ack=0 on the next edge.
REQ-017 Reads are read-first: a read issued in the same cycle as a write to the same word returns the old contents.
REQ-018 Writes update only the lanes with iwb_sel bit = 1.
REQ-019 On a write ack, iwb_dat holds its previous value.
REQ-020 Wait mode FSM states: IDLE, BUSY, ACK.
REQ-021 Wait mode, IDLE: on accept, latch adr/wre/sel/wdt and load the counter with WAIT-1; go to BUSY, or directly to ACK when WAIT=0.
REQ-022 Wait mode, BUSY: decrement the counter each sena cycle; leave for ACK when the counter is 0 on the edge.
REQ-023 Wait mode, ACK: iwb_ack=1 and iwb_dat is valid for exactly one cycle; return to IDLE; iwb_stb is ignored in BUSY and ACK.
REQ-024 Wait-mode latency: an ack arrives WAIT+1 sena cycles after acceptance.
REQ-025 Wait-mode write timing: the write commits on the BUSY→ACK transition, never earlier.
REQ-026 sena=0: FSM, counter, iwb_ack and iwb_dat all hold their values, so an asserted ack persists until the next sena=1 edge.

Reset
REQ-027 srst=1 drives iwb_ack=0, iwb_dat=32'h0, FSM to IDLE, counter to 0, and clears the latched request; srst overrides sena.
REQ-028 Reset mid-operation abandons any pending request: no ack is issued, and an uncommitted write is discarded.
REQ-029 Memory contents are not reset.

Configuration
REQ-030 Macro T5_IMEM_WAIT_EN defined: the wait-state FSM and counter (REQ-020..REQ-025) are compiled in, and WAIT applies.
REQ-031 Macro T5_IMEM_WAIT_EN undefined: the FSM and counter are absent, WAIT is ignored, and the zero-wait pipelined behaviour (REQ-015, REQ-016) applies.

Structure
REQ-032 Shared package t5_pkg holds XLEN (32) and the FSM state encoding constants (IDLE, BUSY, ACK).
REQ-033 Sub-module t5_ram_sp: single-port, synchronous, read-first RAM with per-byte write enables, parameterised by AW; t5_imem instantiates exactly one.

Verification
REQ-034 Zero-wait: write 32'hDEADBEEF to word 5 with sel=4'hF, then read word 5 → iwb_ack=1 one cycle after the read, iwb_dat=32'hDEADBEEF.
REQ-035 Byte lanes: preload word 3 = 32'h11223344, write 32'hAABBCCDD with sel=4'b0101 → subsequent read returns 32'h11BB33DD.
REQ-036 Streaming (zero-wait): stb held high, addresses 0,1,2,3 on consecutive sena cycles → acks on four consecutive cycles, data in address order.
REQ-037 Wait mode, WAIT=2: read accepted at cycle t → single ack at t+3; stb held high during BUSY is not accepted until IDLE.
REQ-038 Stall: sena=0 for 3 cycles while iwb_ack=1 → ack and data held for 3 cycles, then deassert after the next sena=1 edge.
REQ-039 Reset mid-op (wait mode): write accepted, srst pulsed in BUSY → no ack, and the target word keeps its old value on readback.
